// File: rtl/uart_param.sv
`timescale 1ns/1ps
// uart_param: parametrised full-duplex UART, fractional baud ticks, oversampled RX.
// Optional parity bit (adds PARITY_ODD) when UART_PARITY_EN is defined.
module uart_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  input  logic [DATA_BITS-1:0] uart_dat_i,
  input  logic                 uart_wr_i,
  output logic                 uart_busy_o,
  output logic                 uart_tx_o,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] uart_dat_o,
  output logic                 uart_rx_valid_o,
  input  logic                 uart_rd_i,
  output logic                 uart_frame_err_o,
  output logic                 uart_overrun_o,
  output logic                 uart_parity_err_o
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(BAUD * OVERSAMPLE);
  localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(CLK_HZ);
  localparam int CNT_W = $clog2(OVERSAMPLE * 2) + 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  // Fractional accumulator: acc + inc stays below 2*CLK_HZ, so ACC_W bits never overflow.
  logic [ACC_W-1:0] acc_q, acc_sum;
  logic             tick_q;

  assign acc_sum = acc_q + ACC_INC;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else if (acc_sum >= ACC_LIM) begin
      acc_q  <= acc_sum - ACC_LIM;
      tick_q <= 1'b1;
    end else begin
      acc_q  <= acc_sum;
      tick_q <= 1'b0;
    end
  end

  // ---------------- TX ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_SYNC, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t              tx_state_q, tx_state_d;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic                   tx_line_q, tx_line_d;
`ifdef UART_PARITY_EN
  logic                   tx_par_q, tx_par_d;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // TX_SYNC holds the line idle until the first tick so the start bit is a full bit long.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line_d  = tx_line_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (uart_wr_i) begin
          tx_sh_d    = uart_dat_i;
          tx_state_d = TX_SYNC;
`ifdef UART_PARITY_EN
          tx_par_d   = (^uart_dat_i) ^ PARITY_ODD;
`endif
        end
      end
      TX_SYNC: if (tick_q) begin
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
        tx_line_d  = 1'b0;
      end
      TX_START: if (tick_q) begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_sh_q[0];
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      TX_DATA: if (tick_q) begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PAR;
            tx_line_d  = tx_par_q;
`else
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
`endif
          end else begin
            tx_bit_d  = tx_bit_q + BIT_ONE;
            tx_sh_d   = tx_sh_q >> 1;
            tx_line_d = tx_sh_d[0];
          end
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
`ifdef UART_PARITY_EN
      TX_PAR: if (tick_q) begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b1;
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
`endif
      TX_STOP: if (tick_q) begin
        if (tx_cnt_q == STOP_END) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_busy_o = (tx_state_q != TX_IDLE);
  assign uart_tx_o   = tx_line_q;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 deliver;
  logic [DATA_BITS-1:0] dat_q;
  logic                 valid_q, ferr_q, ovr_q;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d, perr_q;
`endif

  // Synchroniser resets to idle-high so reset never fakes a start edge.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    deliver    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (tick_q) begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      RX_DATA: if (tick_q) begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PAR;
`else
            rx_state_d = RX_STOP;
`endif
          end else rx_bit_d = rx_bit_q + BIT_ONE;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
`ifdef UART_PARITY_EN
      RX_PAR: if (tick_q) begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
`endif
      RX_STOP: if (tick_q) begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          deliver    = 1'b1;
          rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A read coinciding with delivery consumes the old byte, so no overrun.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      dat_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (deliver) begin
      dat_q   <= rx_sh_q;
      valid_q <= 1'b1;
      ferr_q  <= ~rx_sync_q;
      ovr_q   <= valid_q & ~uart_rd_i;
`ifdef UART_PARITY_EN
      perr_q  <= (^rx_sh_q) ^ rx_par_q ^ PARITY_ODD;
`endif
    end else if (uart_rd_i && valid_q) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign uart_dat_o       = dat_q;
  assign uart_rx_valid_o  = valid_q;
  assign uart_frame_err_o = ferr_q;
  assign uart_overrun_o   = ovr_q;
`ifdef UART_PARITY_EN
  assign uart_parity_err_o = perr_q;
`else
  assign uart_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param.sv
`timescale 1ns/1ps
// tb_uart_param: directed bench for uart_param at default parameters (434 clocks per bit).
module tb_uart_param;

`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, wr, rd, loop_en, rx_drv, rx_line;
  logic [7:0] dat;
  logic       busy, tx, valid, ferr, ovr, perr;
  logic [7:0] rdat;

  always #10 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_param dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .uart_dat_i(dat), .uart_wr_i(wr), .uart_busy_o(busy), .uart_tx_o(tx),
    .uart_rx_i(rx_line), .uart_dat_o(rdat), .uart_rx_valid_o(valid), .uart_rd_i(rd),
    .uart_frame_err_o(ferr), .uart_overrun_o(ovr), .uart_parity_err_o(perr)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TX edge recorder (cycle stamps)
  logic rec_en = 1'b0, tx_prev = 1'b1;
  int   edges[$];
  always @(negedge clk) begin
    if (rec_en && (tx !== tx_prev)) edges.push_back(cyc);
    tx_prev <= tx;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic inject(input logic [7:0] d, input logic par, input logic stop);
    rx_drv = 1'b0; repeat (434) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx_drv = d[i]; repeat (434) @(negedge clk); end
`ifdef UART_PARITY_EN
    rx_drv = par; repeat (434) @(negedge clk);
`else
    if (par) rx_drv = 1'b1;  // no parity slot in this build
`endif
    rx_drv = stop; repeat (434) @(negedge clk);
    rx_drv = 1'b1; repeat (20) @(negedge clk);
  endtask

  task automatic tx_frame_check(input logic [7:0] d, input bit mid_wr);
    logic [NBITS-1:0] fb;
    int kpos[$];
    int t_end, len, dev, explen;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = d[i];
`ifdef UART_PARITY_EN
    fb[9] = ^d;
`endif
    fb[NBITS-1] = 1'b1;
    edges.delete();
    rec_en = 1'b1;
    @(negedge clk); dat = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    chk("tx_busy_rise", busy, 1);
    for (int i = 0; i < 200 && tx !== 1'b0; i++) @(negedge clk);
    chk("tx_start_seen", tx, 0);
    repeat (217) @(negedge clk);
    for (int k = 0; k < NBITS; k++) begin
      chk($sformatf("tx_bit%0d", k), tx, fb[k]);
      if (k < NBITS - 1) begin
        if (mid_wr && k == 3) begin
          dat = ~d; wr = 1'b1; @(negedge clk); wr = 1'b0;
          repeat (433) @(negedge clk);
        end else repeat (434) @(negedge clk);
      end
    end
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    t_end = cyc;
    chk("tx_busy_fall", busy, 0);
    rec_en = 1'b0;
    for (int k = 0; k < NBITS; k++)
      if (fb[k] != ((k == 0) ? 1'b1 : fb[k-1])) kpos.push_back(k);
    chk("tx_edge_count", edges.size(), kpos.size());
    if (edges.size() == kpos.size() && edges.size() > 0) begin
      len = t_end - edges[0];
      explen = (NBITS * 43403) / 100;
      chk("tx_frame_len_ok", (len >= explen - 2 && len <= explen + 2), 1);
      for (int j = 1; j < edges.size(); j++) begin
        dev = edges[j] - edges[0] - (kpos[j] * 43403) / 100;
        chk($sformatf("tx_edge%0d_pos_ok", j), (dev >= -2 && dev <= 2), 1);
      end
    end
    repeat (40) @(negedge clk);
    chk("tx_no_queue_busy", busy, 0);
    chk("tx_idle_line", tx, 1);
  endtask

  typedef struct {
    logic [7:0] d; logic stop; logic rd_after;
    logic [7:0] e_dat; logic e_valid; logic e_ferr; logic e_ovr;
  } rxvec_t;
  rxvec_t vt[5];

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lb[3];
    int ntx, nrx;
    bit acc_seen, tmo;

    vt[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0};
    vt[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    vt[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vt[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; wr = 1'b0; rd = 1'b0; dat = '0; loop_en = 1'b0; rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_tx", tx, 1);     chk("rst_busy", busy, 0);
    chk("rst_dat", rdat, 0);  chk("rst_valid", valid, 0);
    chk("rst_ferr", ferr, 0); chk("rst_ovr", ovr, 0); chk("rst_perr", perr, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // TX timing with an ignored mid-frame write
    tx_frame_check(8'hA5, 1'b1);

    // Loopback, writes held high so each is taken the cycle busy drops
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
    loop_en = 1'b1;
    @(negedge clk);
    ntx = 0; nrx = 0; tmo = 1'b1;
    dat = lb[0]; wr = 1'b1; acc_seen = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      rd = 1'b0;
      if (acc_seen) begin
        chk($sformatf("lb_busy_after_accept%0d", ntx), busy, 1);
        ntx++;
        if (ntx < 3) dat = lb[ntx]; else wr = 1'b0;
        acc_seen = 1'b0;
      end
      if (wr && !busy) acc_seen = 1'b1;
      if (valid && nrx < 3) begin
        chk($sformatf("lb_dat%0d", nrx), rdat, lb[nrx]);
        chk($sformatf("lb_ferr%0d", nrx), ferr, 0);
        chk($sformatf("lb_ovr%0d", nrx), ovr, 0);
        chk($sformatf("lb_perr%0d", nrx), perr, 0);
        rd = 1'b1;
        nrx++;
      end
      if (nrx == 3 && ntx == 3) begin tmo = 1'b0; break; end
    end
    chk("lb_timeout", tmo, 0);
    wr = 1'b0;
    @(negedge clk); rd = 1'b0;
    repeat (500) @(negedge clk);
    chk("lb_valid_cleared", valid, 0);
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // Start-bit glitch shorter than half a bit
    rx_drv = 1'b0; repeat (100) @(negedge clk);
    rx_drv = 1'b1; repeat (600) @(negedge clk);
    chk("glitch_valid", valid, 0);
    chk("glitch_ferr", ferr, 0);

    // Injected frames: good frame after glitch, framing error, overrun
    for (int i = 0; i < 5; i++) begin
      inject(vt[i].d, ^vt[i].d, vt[i].stop);
      chk($sformatf("vec%0d_dat", i), rdat, vt[i].e_dat);
      chk($sformatf("vec%0d_valid", i), valid, vt[i].e_valid);
      chk($sformatf("vec%0d_ferr", i), ferr, vt[i].e_ferr);
      chk($sformatf("vec%0d_ovr", i), ovr, vt[i].e_ovr);
      chk($sformatf("vec%0d_perr", i), perr, 0);
      if (vt[i].rd_after) begin
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        chk($sformatf("vec%0d_rd_valid", i), valid, 0);
        chk($sformatf("vec%0d_rd_ovr", i), ovr, 0);
      end
    end

    // Reset during data bit 4 on both TX and (looped) RX
    loop_en = 1'b1;
    @(negedge clk); dat = 8'h96; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    for (int i = 0; i < 200 && tx !== 1'b0; i++) @(negedge clk);
    repeat (217 + 434 * 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1); chk("midrst_busy", busy, 0); chk("midrst_valid", valid, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    dat = 8'h69; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    for (int i = 0; i < 6000 && !valid; i++) @(negedge clk);
    chk("postrst_valid", valid, 1);
    chk("postrst_dat", rdat, 8'h69);
    chk("postrst_ferr", ferr, 0);
    rd = 1'b1; @(negedge clk); rd = 1'b0;
    for (int i = 0; i < 600 && busy; i++) @(negedge clk);
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

`ifdef UART_PARITY_EN
    tx_frame_check(8'h07, 1'b0);
    inject(8'h07, 1'b0, 1'b1);
    chk("par_bad_perr", perr, 1);
    chk("par_bad_dat", rdat, 8'h07);
    @(negedge clk); rd = 1'b1; @(negedge clk); rd = 1'b0;
    inject(8'h07, 1'b1, 1'b1);
    chk("par_good_perr", perr, 0);
    chk("par_good_valid", valid, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART, next generation of the fixed 8N1/115200 UART.
- Configurable clock/baud, data width and stop bits; oversampled RX with mid-bit sampling and start-bit glitch rejection.
- Buffered RX with valid/read handshake; framing and overrun error flags.
- Sits between the CPU/peripheral bus glue and the board TX/RX pins.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DATA_BITS, 8, data bits per frame (5..9), LSB first
STOP_BITS, 1, stop bits transmitted (1 or 2); RX checks the first stop bit only
OVERSAMPLE, 16, RX ticks per bit (power of two, 8..16)

Ports:
sys_clk_i  in  1  system clock
sys_rst_i  in  1  synchronous active-high reset
uart_dat_i  in  DATA_BITS  TX data
uart_wr_i  in  1  TX request; accepted when high and uart_busy_o low
uart_busy_o  out  1  TX frame in progress
uart_tx_o  out  1  serial TX line, idle high
uart_rx_i  in  1  serial RX line, asynchronous
uart_dat_o  out  DATA_BITS  last received data
uart_rx_valid_o  out  1  uart_dat_o holds an unread byte
uart_rd_i  in  1  read strobe; clears uart_rx_valid_o
uart_frame_err_o  out  1  stop bit of last frame sampled low (sticky until next good frame)
uart_overrun_o  out  1  byte completed while valid was high (sticky until read)
uart_parity_err_o  out  1  parity mismatch; constant 0 without macro

Behaviour:
- Single clock domain. Synchronous, active-high reset.
- Reset values:
  - uart_tx_o=1; uart_busy_o=0.
  - uart_dat_o=0; all flags 0.
  - Baud accumulators, state machines and counters cleared.
  - Reset mid-frame aborts immediately; TX returns high in the next cycle.
- Tick generator: fractional accumulator, add BAUD*OVERSAMPLE each clock, subtract CLK_HZ on overflow.
  - tick is a 1-cycle pulse.
  - Accumulator width is ceil(log2(CLK_HZ))+1.
  - Long-term rate error is 0.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each state lasts OVERSAMPLE ticks.
  - On accept, the data is latched. uart_busy_o rises the next cycle and stays high until the last stop bit completes.
  - The first tick edge drives the start bit (0).
  - A write while busy is ignored, with no queuing.
  - A write in the same cycle busy falls is accepted.
- RX input: 2-flop synchroniser; all logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a 1->0 transition starts the tick counter.
  - START: at OVERSAMPLE/2 ticks the line is resampled. If high, the start is a glitch and the FSM returns to IDLE with no flags.
  - DATA: each bit is sampled every OVERSAMPLE ticks thereafter (bit centre), shifting LSB first.
  - STOP: sampled at centre.
    - Low: frame_err=1; the data is still delivered.
    - High: frame_err cleared.
    - The FSM re-arms in IDLE right after the stop sample, so back-to-back frames are supported.
- RX delivery at stop sample:
  - uart_dat_o updates and valid=1.
  - If valid was already 1 and not read in that cycle, the data is overwritten and overrun=1.
  - rd in the same cycle as delivery: the new byte wins and valid stays 1, with no overrun.
- uart_rd_i with valid=1 clears valid and overrun next cycle. rd with valid=0 has no effect.
- DATA_BITS<8: uart_dat_o is exactly DATA_BITS wide, and the unused bits do not exist.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0 = even) is added.
  - TX inserts a parity bit after the data.
  - RX samples the parity bit. parity_err is set on mismatch and cleared on a good frame; it is updated with each delivery.
- When undefined:
  - No parity bit in either direction.
  - uart_parity_err_o is tied to 0.
  - The PARITY states are not built.

Test Plan:
- TX timing: default params, write 0xA5 -> uart_tx_o shows 0,1,0,1,0,0,1,0,1,1. Each bit is 434±1 clocks; busy is high for 10 bits; a second write mid-frame is ignored.
- Loopback: tie tx->rx and send 0x00, 0xFF, 0x3C back-to-back (wr at busy fall) -> each byte is delivered with valid=1, read between frames; no errors.
- Glitch rejection: rx low for 100 clocks (< half bit) -> no valid and the FSM is idle. Then a full frame for 0x5A is received correctly.
- Framing/overrun:
  - Inject 0x81 with a low stop bit -> frame_err=1, dat=0x81.
  - Then two good frames without rd -> overrun=1, frame_err=0, dat=the second byte.
  - rd -> valid=0, overrun=0.
- Reset mid-frame: assert sys_rst_i during TX bit 4 and RX bit 4 -> next cycle tx=1, busy=0, valid=0; the next frame works.
- Parity (UART_PARITY_EN, even): send 0x07 -> parity bit 1. Inject 0x07 with parity 0 -> parity_err=1.
